// File: rtl/decod_scan_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : decod_scan_ctrl_pkg
//  Description : Shared state encoding, widths and helpers for the
//                time-multiplexed row/segment decoder scan controller.
//  Revision    : 1.0 - initial release
// ============================================================================
package decod_scan_ctrl_pkg;

    // Width of one row code: bit2=A, bit1=B, bit0=C
    localparam int CODE_W   = 3;
    // The shared 3-bit decoder can address at most this many rows
    localparam int MAX_ROWS = 8;
    // Row index width, sized for MAX_ROWS
    localparam int IDX_W    = 3;

    // Scan sequencer state encoding
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_BLANK = 2'd1;
    localparam logic [1:0] ST_SHOW  = 2'd2;

    // Row index after idx, wrapping from last back to row 0
    function automatic logic [IDX_W-1:0] next_row(
        input logic [IDX_W-1:0] idx,
        input logic [IDX_W-1:0] last
    );
        return (idx == last) ? '0 : idx + IDX_W'(1);
    endfunction

endpackage
`default_nettype wire

// File: rtl/decod_scan_bank.sv
`default_nettype none
// ============================================================================
//  Module      : decod_scan_bank
//  Description : ROWS x 3-bit double-buffered code bank. The host writes the
//                shadow copy; the whole shadow is copied into the active copy
//                on swap. The read port returns the active code for rd_idx,
//                or the code being swapped in when swap is high so the
//                caller can present the new value on the swap cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module decod_scan_bank
    import decod_scan_ctrl_pkg::*;
#(
    parameter int ROWS = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic              swap,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [CODE_W-1:0] rd_data
);

    logic [CODE_W-1:0] r_shadow [ROWS];
    logic [CODE_W-1:0] r_active [ROWS];

    // Shadow write port and shadow->active copy; the copy takes the
    // pre-write shadow contents when both happen in the same cycle.
    // Addresses at or beyond ROWS match no entry and are dropped.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROWS; i++) begin
                r_shadow[i] <= '0;
                r_active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < ROWS; i++) begin
                if (swap) begin
                    r_active[i] <= r_shadow[i];
                end
                if (wr_en && (wr_addr == IDX_W'(i))) begin
                    r_shadow[i] <= wr_data;
                end
            end
        end
    end

    // Read mux with swap bypass so the incoming code is visible immediately
    always_comb begin
        rd_data = '0;
        for (int i = 0; i < ROWS; i++) begin
            if (rd_idx == IDX_W'(i)) begin
                rd_data = swap ? r_shadow[i] : r_active[i];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/decod_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : decod_scan_ctrl
//  Description : Time-multiplexed scan controller for a shared 3-bit
//                row/segment decoder. Steps through ROWS rows, each preceded
//                by BLANK all-off cycles and then enabled for DWELL cycles.
//                Host code updates land in a shadow bank and are swapped in
//                only at a frame boundary (entry into row 0), or immediately
//                while idle.
//  Revision    : 1.0 - initial release
// ============================================================================
module decod_scan_ctrl
    import decod_scan_ctrl_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int DWELL = 1000,
    parameter int BLANK = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              wr_en,
    input  logic [IDX_W-1:0]  wr_addr,
    input  logic [CODE_W-1:0] wr_data,
    input  logic              commit,
    output logic              A,
    output logic              B,
    output logic              C,
    output logic [ROWS-1:0]   row_en_n,
    output logic              frame_start,
    output logic              commit_done,
    output logic              busy
);

    localparam logic [CNT_W-1:0] c_dwell_last  = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] c_blank_last  = CNT_W'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [1:0]       c_first_phase = (BLANK > 0) ? ST_BLANK : ST_SHOW;
    localparam logic [IDX_W-1:0] c_last_row    = IDX_W'(ROWS - 1);

    logic [1:0]        r_state;
    logic [IDX_W-1:0]  r_row_idx;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_pending;
    logic [CODE_W-1:0] r_code;
    logic [ROWS-1:0]   r_row_en_n;
    logic              r_frame_start;
    logic              r_commit_done;
    logic              r_busy;

    logic [1:0]        w_nxt_state;
    logic [IDX_W-1:0]  w_nxt_idx;
    logic [CNT_W-1:0]  w_nxt_cnt;
    logic              w_enter_row;
    logic              w_boundary;
    logic              w_swap;
    logic              w_nxt_pending;
    logic [ROWS-1:0]   w_nxt_row_en_n;
    logic [CODE_W-1:0] w_rd_data;

    // Code bank; reads the row about to be presented so the registered
    // code lines up with the registered row enables
    decod_scan_bank #(
        .ROWS (ROWS)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .swap    (w_swap),
        .rd_idx  (w_nxt_idx),
        .rd_data (w_rd_data)
    );

    // Next-state sequencing: phase counters, row advance, and row entry
    always_comb begin
        w_nxt_state = ST_IDLE;
        w_nxt_idx   = '0;
        w_nxt_cnt   = '0;
        w_enter_row = 1'b0;
        if (en) begin
            case (r_state)
                ST_IDLE: begin
                    w_nxt_state = c_first_phase;
                    w_enter_row = 1'b1;
                end
                ST_BLANK: begin
                    w_nxt_idx = r_row_idx;
                    if (r_cnt == c_blank_last) begin
                        w_nxt_state = ST_SHOW;
                    end else begin
                        w_nxt_state = ST_BLANK;
                        w_nxt_cnt   = r_cnt + CNT_W'(1);
                    end
                end
                ST_SHOW: begin
                    if (r_cnt == c_dwell_last) begin
                        w_nxt_state = c_first_phase;
                        w_nxt_idx   = next_row(r_row_idx, c_last_row);
                        w_enter_row = 1'b1;
                    end else begin
                        w_nxt_state = ST_SHOW;
                        w_nxt_idx   = r_row_idx;
                        w_nxt_cnt   = r_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    w_nxt_state = ST_IDLE;
                end
            endcase
        end
    end

    // Swap decision, pending-commit tracking and next row-enable pattern.
    // A swap happens on entry into row 0, or straight away while idle.
    always_comb begin
        w_boundary     = w_enter_row && (w_nxt_idx == '0);
        w_swap         = (commit || r_pending) &&
                         (w_boundary || ((r_state == ST_IDLE) && !en));
        w_nxt_pending  = !w_swap && (commit || r_pending);
        w_nxt_row_en_n = '1;
        for (int i = 0; i < ROWS; i++) begin
            if ((w_nxt_state == ST_SHOW) && (w_nxt_idx == IDX_W'(i))) begin
                w_nxt_row_en_n[i] = 1'b0;
            end
        end
    end

    // Sequencer state and registered outputs; the code lines hold their
    // last value while idle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_row_idx     <= '0;
            r_cnt         <= '0;
            r_pending     <= 1'b0;
            r_code        <= '0;
            r_row_en_n    <= '1;
            r_frame_start <= 1'b0;
            r_commit_done <= 1'b0;
            r_busy        <= 1'b0;
        end else begin
            r_state       <= w_nxt_state;
            r_row_idx     <= w_nxt_idx;
            r_cnt         <= w_nxt_cnt;
            r_pending     <= w_nxt_pending;
            r_row_en_n    <= w_nxt_row_en_n;
            r_frame_start <= w_boundary;
            r_commit_done <= w_swap;
            r_busy        <= (w_nxt_state != ST_IDLE);
            if (w_nxt_state != ST_IDLE) begin
                r_code <= w_rd_data;
            end
        end
    end

    assign {A, B, C}   = r_code;
    assign row_en_n    = r_row_en_n;
    assign frame_start = r_frame_start;
    assign commit_done = r_commit_done;
    assign busy        = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_decod_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_decod_scan_ctrl
//  Description : Self-checking bench for decod_scan_ctrl. Two instances share
//                the stimulus: one with a blank phase and one without. Each
//                is compared every cycle against a frame-position model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_decod_scan_ctrl;

    localparam int ROWS  = 3;
    localparam int DWELL = 4;
    localparam int BLK0  = 2;
    localparam int BLK1  = 0;

    logic       clk     = 1'b0;
    logic       rst_n   = 1'b0;
    logic       en      = 1'b0;
    logic       wr_en   = 1'b0;
    logic       commit  = 1'b0;
    logic [2:0] wr_addr = 3'd0;
    logic [2:0] wr_data = 3'd0;

    logic            d0_a, d0_b, d0_c, d0_fs, d0_cd, d0_busy;
    logic [ROWS-1:0] d0_ren;
    logic            d1_a, d1_b, d1_c, d1_fs, d1_cd, d1_busy;
    logic [ROWS-1:0] d1_ren;

    int check_cnt = 0;
    int fail_cnt  = 0;

    // Reference model state, one slot per instance
    int         blk      [2];
    bit         m_run    [2];
    int         m_p      [2];
    logic [2:0] m_sh     [2][3];
    logic [2:0] m_ac     [2][3];
    bit         m_pend   [2];
    logic [2:0] m_code   [2];
    logic [2:0] m_ren    [2];
    bit         m_fs     [2];
    bit         m_cd     [2];

    always #5 clk = ~clk;

    decod_scan_ctrl #(.ROWS(ROWS), .DWELL(DWELL), .BLANK(BLK0), .CNT_W(16)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .A(d0_a), .B(d0_b), .C(d0_c),
        .row_en_n(d0_ren), .frame_start(d0_fs), .commit_done(d0_cd), .busy(d0_busy)
    );

    decod_scan_ctrl #(.ROWS(ROWS), .DWELL(DWELL), .BLANK(BLK1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .en(en), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .A(d1_a), .B(d1_b), .C(d1_c),
        .row_en_n(d1_ren), .frame_start(d1_fs), .commit_done(d1_cd), .busy(d1_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        check_cnt++;
        if (got !== exp) begin
            fail_cnt++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_run[k]  = 1'b0;
            m_p[k]    = 0;
            m_pend[k] = 1'b0;
            m_code[k] = 3'd0;
            m_ren[k]  = 3'b111;
            m_fs[k]   = 1'b0;
            m_cd[k]   = 1'b0;
            for (int i = 0; i < 3; i++) begin
                m_sh[k][i] = 3'd0;
                m_ac[k][i] = 3'd0;
            end
        end
    endtask

    // Frame-position model: p counts cycles since the frame started; row and
    // phase follow from p with plain division by the per-row period.
    task automatic model_step(input int k);
        int per = blk[k] + DWELL;
        int len = ROWS * per;
        int row;
        int off;
        bit was = m_run[k];
        bit bnd = 1'b0;
        bit sw;
        if (!en) begin
            m_run[k] = 1'b0;
        end else if (!was) begin
            m_run[k] = 1'b1;
            m_p[k]   = 0;
            bnd      = 1'b1;
        end else begin
            m_p[k] = (m_p[k] + 1) % len;
            bnd    = (m_p[k] == 0);
        end
        sw = (commit || m_pend[k]) && (bnd || (!was && !en));
        if (sw) begin
            for (int i = 0; i < 3; i++) m_ac[k][i] = m_sh[k][i];
        end
        if (wr_en && (int'(wr_addr) < ROWS)) m_sh[k][wr_addr] = wr_data;
        m_pend[k] = sw ? 1'b0 : (commit ? 1'b1 : m_pend[k]);
        m_fs[k]   = bnd;
        m_cd[k]   = sw;
        if (m_run[k]) begin
            row       = m_p[k] / per;
            off       = m_p[k] % per;
            m_code[k] = m_ac[k][row];
            m_ren[k]  = (off < blk[k]) ? 3'b111 : 3'(~(3'b001 << row));
        end else begin
            m_ren[k] = 3'b111;
        end
    endtask

    task automatic compare_all();
        check("d0_row_en_n", 32'(d0_ren), 32'(m_ren[0]));
        check("d0_code", 32'({d0_a, d0_b, d0_c}), 32'(m_code[0]));
        check("d0_frame_start", 32'(d0_fs), 32'(m_fs[0]));
        check("d0_commit_done", 32'(d0_cd), 32'(m_cd[0]));
        check("d0_busy", 32'(d0_busy), 32'(m_run[0]));
        check("d1_row_en_n", 32'(d1_ren), 32'(m_ren[1]));
        check("d1_code", 32'({d1_a, d1_b, d1_c}), 32'(m_code[1]));
        check("d1_frame_start", 32'(d1_fs), 32'(m_fs[1]));
        check("d1_commit_done", 32'(d1_cd), 32'(m_cd[1]));
        check("d1_busy", 32'(d1_busy), 32'(m_run[1]));
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            model_step(0);
            model_step(1);
        end
        #1;
        compare_all();
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    // Advance until instance 0 sits at frame position pos (bounded)
    task automatic wait_pos(input int pos);
        bit found = 1'b0;
        for (int n = 0; n < 100; n++) begin
            if (m_run[0] && (m_p[0] == pos)) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("wait_pos_reached", 32'(found), 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_d0_row_en_n"}, 32'(d0_ren), 32'b111);
        check({tag, "_d0_code"}, 32'({d0_a, d0_b, d0_c}), 32'd0);
        check({tag, "_d0_busy"}, 32'(d0_busy), 32'd0);
        check({tag, "_d0_fs_cd"}, 32'({d0_fs, d0_cd}), 32'd0);
        check({tag, "_d1_row_en_n"}, 32'(d1_ren), 32'b111);
        check({tag, "_d1_busy"}, 32'(d1_busy), 32'd0);
    endtask

    initial begin
        blk[0] = BLK0;
        blk[1] = BLK1;
        model_reset();

        // Reset values
        #12;
        check_reset_outputs("reset");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Free-running scan with all-zero codes
        en = 1'b1;
        tick();
        check("first_blank_fs", 32'(d0_fs), 32'd1);
        check("first_blank_ren", 32'(d0_ren), 32'b111);
        check("noblank_first_show", 32'(d1_ren), 32'b110);
        run(40);

        // Load new codes, commit mid-row-1; visible only from next row 0
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 3'b101; tick();
        wr_addr = 3'd1; wr_data = 3'b011; tick();
        wr_addr = 3'd2; wr_data = 3'b110; tick();
        wr_en = 1'b0;
        wait_pos(9);
        commit = 1'b1; tick(); commit = 1'b0;
        check("pending_no_early_swap", 32'(d0_cd), 32'd0);
        wait_pos(0);
        check("swap_cd_at_boundary", 32'({d0_cd, d0_fs}), 32'b11);
        wait_pos(2);
        check("row0_new_code", 32'({d0_a, d0_b, d0_c}), 32'b101);
        check("row0_show_ren", 32'(d0_ren), 32'b110);
        wait_pos(14);
        check("row2_new_code", 32'({d0_a, d0_b, d0_c}), 32'b110);

        // Commit plus write on the boundary edge: swap takes pre-write shadow
        wait_pos(17);
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 3'b111; commit = 1'b1;
        tick();
        wr_en = 1'b0; commit = 1'b0;
        check("bnd_commit_cd", 32'({d0_cd, d0_fs}), 32'b11);
        wait_pos(8);
        check("row1_prewrite_code", 32'({d0_a, d0_b, d0_c}), 32'b011);
        wait_pos(10);
        commit = 1'b1; tick(); commit = 1'b0;
        wait_pos(8);
        check("row1_second_commit", 32'({d0_a, d0_b, d0_c}), 32'b111);

        // Drop enable during row-2 show, then restart from row 0
        wait_pos(14);
        en = 1'b0; tick();
        check("en_drop_ren", 32'(d0_ren), 32'b111);
        check("en_drop_busy", 32'(d0_busy), 32'd0);
        run(3);
        en = 1'b1; tick();
        check("restart_fs", 32'({d0_fs, d0_busy}), 32'b11);
        tick();
        check("restart_blank2", 32'(d0_ren), 32'b111);
        tick();
        check("restart_row0", 32'(d0_ren), 32'b110);

        // Randomised traffic
        for (int n = 0; n < 1500; n++) begin
            en      = ($urandom_range(0, 31) != 0);
            commit  = ($urandom_range(0, 15) == 0);
            wr_en   = ($urandom_range(0, 3) == 0);
            wr_addr = 3'($urandom_range(0, 7));
            wr_data = 3'($urandom_range(0, 7));
            tick();
        end
        commit = 1'b0;
        wr_en  = 1'b0;
        en     = 1'b1;

        // Asynchronous reset mid-show with an out-of-range write pending
        wait_pos(4);
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 3'b111;
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        run(2);
        rst_n = 1'b1;
        commit = 1'b1; tick(); commit = 1'b0;
        run(40);
        check("oob_write_code", 32'({d0_a, d0_b, d0_c, d1_a, d1_b, d1_c}), 32'd0);
        wr_en = 1'b0;
        run(4);

        $display("TB_RESULT checks=%0d failures=%0d", check_cnt, fail_cnt);
        $finish;
    end

endmodule
`default_nettype wire
